// File: rtl/hash_lane_scheduler_if.sv
// rtl/hash_lane_scheduler_if.sv - requester/lane bundle for the hash lane scheduler
interface hash_lane_scheduler_if #(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 31
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [2*NUM_REQ-1:0]           req_opt;
    logic [NUM_REQ*INDEX_WIDTH-1:0] req_index;
    logic [NUM_REQ*KEY_WIDTH-1:0]   req_key;
    logic [NUM_REQ*VALUE_WIDTH-1:0] req_value;
    logic                           lane_ready;
    logic                           out_en;
    logic [1:0]                     out_opt;
    logic [INDEX_WIDTH-1:0]         out_index;
    logic [KEY_WIDTH-1:0]           out_key;
    logic [VALUE_WIDTH-1:0]         out_value;
    logic [GID_W-1:0]               out_grant_id;
    logic [15:0]                    hazard_stall_cnt;

    modport slave (
        input  req_valid, req_opt, req_index, req_key, req_value, lane_ready,
        output req_ready, out_en, out_opt, out_index, out_key, out_value,
               out_grant_id, hazard_stall_cnt
    );

    modport master (
        output req_valid, req_opt, req_index, req_key, req_value, lane_ready,
        input  req_ready, out_en, out_opt, out_index, out_key, out_value,
               out_grant_id, hazard_stall_cnt
    );
endinterface

// File: rtl/hash_lane_scheduler.sv
// rtl/hash_lane_scheduler.sv - round-robin lane scheduler with in-flight write hazard blocking
module hash_lane_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 31,
    parameter int PIPE_DEPTH  = 7
) (
    input logic clk,
    input logic reset,
    hash_lane_scheduler_if.slave bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = GID_W + 1;

    logic [PIPE_DEPTH-1:0]  sb_valid_q;
    logic [INDEX_WIDTH-1:0] sb_index_q [PIPE_DEPTH];
    logic [GID_W-1:0]       rr_ptr_q;
    logic                   out_en_q;
    logic [1:0]             out_opt_q;
    logic [INDEX_WIDTH-1:0] out_index_q;
    logic [KEY_WIDTH-1:0]   out_key_q;
    logic [VALUE_WIDTH-1:0] out_value_q;
    logic [GID_W-1:0]       out_grant_id_q;
    logic [15:0]            stall_cnt_q;

    logic [NUM_REQ-1:0]     hazard;
    logic [NUM_REQ-1:0]     eligible;
    logic                   grant_found;
    logic [GID_W-1:0]       grant_id;
    logic [GID_W-1:0]       rr_next;
    logic [CW-1:0]          cand;
    logic [1:0]             sel_opt;
    logic [INDEX_WIDTH-1:0] sel_index;
    logic [KEY_WIDTH-1:0]   sel_key;
    logic [VALUE_WIDTH-1:0] sel_value;
    logic                   wr_grant;
    logic                   stall;

    // Any in-flight write to the same index blocks both reads and writes.
    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int d = 0; d < PIPE_DEPTH; d++) begin
                if (sb_valid_q[d] &&
                    sb_index_q[d] == bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH]) begin
                    hazard[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = bus.req_valid & ~hazard & {NUM_REQ{bus.lane_ready & ~reset}};

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = CW'(rr_ptr_q) + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!grant_found && eligible[cand[GID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[GID_W-1:0];
            end
        end
    end

    assign rr_next   = (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign sel_opt   = bus.req_opt[grant_id*2 +: 2];
    assign sel_index = bus.req_index[grant_id*INDEX_WIDTH +: INDEX_WIDTH];
    assign sel_key   = bus.req_key[grant_id*KEY_WIDTH +: KEY_WIDTH];
    assign sel_value = bus.req_value[grant_id*VALUE_WIDTH +: VALUE_WIDTH];
    // The reserved opt encoding is treated as writing, so it also guards its index.
    assign wr_grant  = grant_found && (sel_opt != 2'b00);
    assign stall     = bus.lane_ready && (|bus.req_valid) && !grant_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_en_q       <= 1'b0;
            out_opt_q      <= '0;
            out_index_q    <= '0;
            out_key_q      <= '0;
            out_value_q    <= '0;
            out_grant_id_q <= '0;
            rr_ptr_q       <= '0;
            sb_valid_q     <= '0;
            stall_cnt_q    <= '0;
            for (int d = 0; d < PIPE_DEPTH; d++) begin
                sb_index_q[d] <= '0;
            end
        end else begin
            out_en_q <= grant_found;
            if (grant_found) begin
                out_opt_q      <= sel_opt;
                out_index_q    <= sel_index;
                out_key_q      <= sel_key;
                out_value_q    <= sel_value;
                out_grant_id_q <= grant_id;
                rr_ptr_q       <= rr_next;
            end
            sb_valid_q    <= {sb_valid_q[PIPE_DEPTH-2:0], wr_grant};
            sb_index_q[0] <= sel_index;
            for (int d = 1; d < PIPE_DEPTH; d++) begin
                sb_index_q[d] <= sb_index_q[d-1];
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.req_ready        = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.out_en           = out_en_q;
    assign bus.out_opt          = out_opt_q;
    assign bus.out_index        = out_index_q;
    assign bus.out_key          = out_key_q;
    assign bus.out_value        = out_value_q;
    assign bus.out_grant_id     = out_grant_id_q;
    assign bus.hazard_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hash_lane_scheduler.sv
// tb/tb_hash_lane_scheduler.sv - scoreboard bench for hash_lane_scheduler
module tb_hash_lane_scheduler;
    localparam int NR = 4;
    localparam int IW = 12;
    localparam int KW = 32;
    localparam int VW = 31;
    localparam int PD = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hash_lane_scheduler_if #(.NUM_REQ(NR), .INDEX_WIDTH(IW), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

    hash_lane_scheduler #(
        .NUM_REQ(NR), .INDEX_WIDTH(IW), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  opt;
        logic [IW-1:0] idx;
        logic [KW-1:0] key;
        logic [VW-1:0] val;
        int          gid;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rv   [NR];
    logic [1:0]    ropt [NR];
    logic [IW-1:0] ridx [NR];
    logic [KW-1:0] rkey [NR];
    logic [VW-1:0] rval [NR];
    logic          lr;
    logic          rst;

    // Reference state: RR pointer, cycle of the latest writing grant per index, stall count.
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   m_wr[int];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit hz(input int i);
        int k;
        k = int'(ridx[i]);
        if (!m_wr.exists(k)) return 1'b0;
        return (cyc - m_wr[k] >= 1) && (cyc - m_wr[k] <= PD);
    endfunction

    task automatic step(output int gid);
        logic [NR-1:0] er;
        bit            any_v;
        exp_t          e;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = rv[i];
            bus.req_opt[2*i +: 2]     = ropt[i];
            bus.req_index[i*IW +: IW] = ridx[i];
            bus.req_key[i*KW +: KW]   = rkey[i];
            bus.req_value[i*VW +: VW] = rval[i];
        end
        bus.lane_ready = lr;
        reset = rst;
        #1;
        gid = -1;
        any_v = 1'b0;
        for (int i = 0; i < NR; i++) any_v |= rv[i];
        if (!rst && lr) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (gid < 0 && rv[c] && !hz(c)) gid = c;
            end
        end
        er = '0;
        if (gid >= 0) er[gid] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        if (rst) begin
            m_wr.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else if (gid >= 0) begin
            e.cyc = cyc + 1; e.opt = ropt[gid]; e.idx = ridx[gid];
            e.key = rkey[gid]; e.val = rval[gid]; e.gid = gid;
            exp_q.push_back(e);
            m_ptr = (gid + 1) % NR;
            if (ropt[gid] != 2'b00) m_wr[int'(ridx[gid])] = cyc;
        end else if (lr && any_v && m_cnt < 65535) begin
            m_cnt++;
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_en", 64'(bus.out_en), 64'(1));
            if (bus.out_en) begin
                chk("out_opt_idx_gid", {bus.out_opt, bus.out_index, bus.out_grant_id},
                    {e.opt, e.idx, 2'(e.gid)});
                chk("out_key", 64'(bus.out_key), 64'(e.key));
                chk("out_value", 64'(bus.out_value), 64'(e.val));
            end
        end else begin
            chk("out_en_idle", 64'(bus.out_en), 64'(0));
        end
        chk("stall_cnt", 64'(bus.hazard_stall_cnt), 64'(m_cnt));
    end

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            rv[i] = 1'b0; ropt[i] = 2'b00; ridx[i] = '0; rkey[i] = '0; rval[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [IW-1:0] x,
                           input logic [KW-1:0] k, input logic [VW-1:0] v);
        rv[i] = 1'b1; ropt[i] = o; ridx[i] = x; rkey[i] = k; rval[i] = v;
    endtask

    task automatic chk_zero_outs(input string name);
        chk(name, {bus.out_en, bus.out_opt, bus.out_index, bus.out_grant_id, bus.hazard_stall_cnt}, 64'(0));
        chk({name, "_kv"}, {1'b0, bus.out_key, bus.out_value}, 64'(0));
    endtask

    initial begin
        int g;
        int n;
        int base;
        clear_reqs();
        lr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        step(g);
        step(g);
        chk_zero_outs("reset_state");

        // Round-robin across four distinct reads
        rst = 1'b0;
        lr = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 2'b00, IW'(12'h010 + i), KW'(32'hA000 + i), VW'(i));
        for (int s = 0; s < 5; s++) begin
            step(g);
            chk("rr_order", 64'(g), 64'(s % NR));
        end
        clear_reqs();
        chk("rr_cnt", 64'(bus.hazard_stall_cnt), 64'(0));

        // Read blocked behind an in-flight write to the same index
        base = m_cnt;
        set_req(0, 2'b01, 12'h05A, 32'hDEADBEEF, 31'h1234);
        step(g);
        chk("raw_write_grant", 64'(g), 64'(0));
        rv[0] = 1'b0;
        set_req(1, 2'b00, 12'h05A, 32'h11111111, 31'h0);
        n = 0;
        g = -1;
        while (g != 1 && n < 20) begin
            step(g);
            n++;
        end
        chk("raw_wait_cycles", 64'(n), 64'(8));
        chk("raw_stall_cnt", 64'(bus.hazard_stall_cnt), 64'(base + 7));
        clear_reqs();

        // Neighbouring index is not blocked
        base = m_cnt;
        set_req(2, 2'b01, 12'h100, 32'h22222222, 31'h2);
        set_req(3, 2'b00, 12'h101, 32'h33333333, 31'h3);
        step(g);
        chk("adj_first", 64'(g), 64'(2));
        rv[2] = 1'b0;
        step(g);
        chk("adj_second", 64'(g), 64'(3));
        clear_reqs();
        chk("adj_cnt", 64'(bus.hazard_stall_cnt), 64'(base));

        // Lane bubbles age out the hazard
        set_req(0, 2'b11, 12'h7FF, 32'h44444444, 31'h4);
        step(g);
        chk("age_write_grant", 64'(g), 64'(0));
        rv[0] = 1'b0;
        set_req(1, 2'b00, 12'h7FF, 32'h55555555, 31'h5);
        lr = 1'b0;
        repeat (10) step(g);
        lr = 1'b1;
        step(g);
        chk("age_read_grant", 64'(g), 64'(1));
        clear_reqs();
        chk("age_cnt", 64'(bus.hazard_stall_cnt), 64'(base));

        // Reset mid-hazard discards the scoreboard
        set_req(2, 2'b01, 12'h020, 32'h66666666, 31'h6);
        step(g);
        chk("rst_write_grant", 64'(g), 64'(2));
        rv[2] = 1'b0;
        set_req(3, 2'b00, 12'h020, 32'h77777777, 31'h7);
        repeat (3) step(g);
        rst = 1'b1;
        step(g);
        chk_zero_outs("mid_reset");
        step(g);
        rst = 1'b0;
        step(g);
        chk("post_reset_grant", 64'(g), 64'(3));
        clear_reqs();

        // Randomized traffic over a small index space to provoke hazards
        for (int s = 0; s < 3000; s++) begin
            lr = ($urandom_range(0, 99) < 85);
            step(g);
            for (int i = 0; i < NR; i++) begin
                if (g == i) rv[i] = 1'b0;
                else if (rv[i] && $urandom_range(0, 15) == 0) rv[i] = 1'b0;
                if (!rv[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 2'($urandom), IW'($urandom_range(0, 7)), $urandom, VW'($urandom));
            end
        end
        clear_reqs();
        lr = 1'b1;

        // Back-to-back writes to one index until the stall counter saturates
        set_req(0, 2'b01, 12'h003, 32'h88888888, 31'h8);
        for (int s = 0; s < 76000; s++) step(g);
        chk("stall_saturate", 64'(bus.hazard_stall_cnt), 64'(16'hFFFF));
        clear_reqs();
        repeat (4) step(g);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_lane_scheduler.md
Name: hash_lane_scheduler

Overview:
- Front-end scheduler for one hash-table write/read lane of the URAM XOR-replicated table.
- Arbitrates round-robin among NUM_REQ hash-function requesters (valid/ready) and issues at most one op per cycle to the lane (index, key, value, opt, en).
- Tracks in-flight writes/deletes for PIPE_DEPTH cycles and withholds grant from any request whose index collides with one of them, so every access sees committed table state.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INDEX_WIDTH, 12, table index width
KEY_WIDTH, 32, key width
VALUE_WIDTH, 31, value width
PIPE_DEPTH, 7, cycles from lane issue until the write is committed (4 extra stages + 3 stages)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (combinational grant)
req_opt  in  2*NUM_REQ  per-requester opt: 00 read, 01 write, 11 delete, 10 reserved
req_index  in  NUM_REQ*INDEX_WIDTH  per-requester table index
req_key  in  NUM_REQ*KEY_WIDTH  per-requester key
req_value  in  NUM_REQ*VALUE_WIDTH  per-requester value
lane_ready  in  1  lane can take an op this cycle
out_en  out  1  registered issue strobe to lane
out_opt  out  2  registered opt
out_index  out  INDEX_WIDTH  registered index
out_key  out  KEY_WIDTH  registered key
out_value  out  VALUE_WIDTH  registered value
out_grant_id  out  clog2(NUM_REQ)  requester that owns the issued op
hazard_stall_cnt  out  16  saturating hazard-stall counter

Behaviour:
- Reset: all out_* = 0, req_ready = 0, RR pointer = 0, scoreboard cleared, hazard_stall_cnt = 0. Reset mid-operation discards all in-flight scoreboard entries; pending requests are simply re-arbitrated afterwards.
- Writing op: opt != 00 (01, 11 and reserved 10); read: opt == 00.
- Scoreboard: PIPE_DEPTH-entry shift register of {valid, index}, shifted every cycle unconditionally.
  - Entry 0 loads {1, index} when a writing op is granted this cycle; otherwise entry 0 loads {0, x}.
  - The oldest entry drops out.
- Hazard: requester i is hazarded if any valid scoreboard entry index == req_index[i]. This applies to reads and writes alike.
- Same-cycle collisions: no comparison is made between requesters in the same cycle. Only one op issues per cycle, and it is in the scoreboard the next cycle.
- Eligible: req_valid[i] && !hazard[i] && lane_ready.
- Grant: first eligible requester searching from the RR pointer upward, modulo NUM_REQ.
  - req_ready[grant] = 1; all other req_ready bits = 0.
  - After a grant, pointer = grant+1 mod NUM_REQ. With no grant, the pointer holds.
- Handshake: transfer when req_valid && req_ready. A requester holds opt/index/key/value stable while valid and not ready. Dropping valid without a transfer is allowed.
- Issue latency: 1 cycle.
  - Cycle after a grant: out_en = 1; out_* carry the granted fields; out_grant_id = grant.
  - Cycle after no grant: out_en = 0; other outputs hold their previous values.
- lane_ready = 0: no grant and out_en = 0 next cycle. The scoreboard still shifts, so bubbles age out hazards.
- hazard_stall_cnt: +1 in each cycle where lane_ready = 1, at least one req_valid = 1, and no grant occurs (all valid requesters are hazarded). Saturates at 16'hFFFF.
- Back-to-back: the same requester may be granted on consecutive cycles only if it is the sole eligible one.
- Repeated same-index writes: a writing op to index X blocks further accesses to X for exactly PIPE_DEPTH cycles after issue. The next access to X is grantable in cycle issue+PIPE_DEPTH+1 and shows out_en at issue+PIPE_DEPTH+2.

Test Plan:
- Reset, then req_valid = 4'b1111, distinct indices, all read, lane_ready = 1 -> grants 0,1,2,3,0,... one per cycle; out_en = 1 from cycle 2; hazard_stall_cnt = 0.
- Req0 writes index 0x05A (key 0xDEADBEEF, value 0x1234), then req1 reads 0x05A -> req1 held 7 cycles; cnt += 7 (req1 only valid); req1 out_en 9 cycles after req0's issue.
- Req2 writes 0x100 while req3 requests 0x101 -> req3 granted the next cycle, no stall.
- lane_ready = 0 for 10 cycles after a write to 0x7FF, then 1 with a pending read of 0x7FF -> read granted immediately (hazard aged out); cnt unchanged.
- Reset asserted 3 cycles after a write to 0x020 with the read of 0x020 pending -> all outputs 0 during reset; read granted the first cycle after reset release.
- Force 70000 hazard-only cycles -> hazard_stall_cnt saturates at 16'hFFFF.
